// File: rtl/sync_fifo_stream_reader_if.sv
// rtl/sync_fifo_stream_reader_if.sv - FIFO registered-read port plus valid/ready stream bundle
interface sync_fifo_stream_reader_if #(
    parameter int WIDTH = 32
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_r_data;
    logic             fifo_r_data_valid;
    logic             fifo_r_en;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;

    // The reader drains the FIFO and sources the stream.
    modport master (
        input  fifo_empty,
        input  fifo_r_data,
        input  fifo_r_data_valid,
        output fifo_r_en,
        output m_valid,
        output m_data,
        input  m_ready
    );

    // FIFO plus downstream consumer.
    modport slave (
        output fifo_empty,
        output fifo_r_data,
        output fifo_r_data_valid,
        input  fifo_r_en,
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/sync_fifo_stream_reader.sv
// rtl/sync_fifo_stream_reader.sv - drains a registered-read sync FIFO into a valid/ready stream via a skid buffer
module sync_fifo_stream_reader #(
    parameter int WIDTH      = 32,
    parameter int SKID_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    sync_fifo_stream_reader_if.master     bus,
    output logic [$clog2(SKID_DEPTH):0]   buf_count
);
    localparam int PW = $clog2(SKID_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = PW + 2;

    logic [WIDTH-1:0] skid_mem [SKID_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             empty_q;
    logic             inflight;
    logic             pop;
    logic             capture;
    logic [SW-1:0]    credit_used;

    assign pop     = bus.m_valid && bus.m_ready;
    assign capture = bus.fifo_r_data_valid && inflight;

    // Credits already committed: held words plus the one in flight, less the one leaving now.
    // pop implies count>=1, so the subtraction never wraps.
    assign credit_used   = SW'(count) + SW'(inflight) - SW'(pop);
    assign bus.fifo_r_en = !empty_q && (credit_used < SW'(SKID_DEPTH));

    assign bus.m_valid = (count != '0);
    assign bus.m_data  = skid_mem[rd_ptr];
    assign buf_count   = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            empty_q  <= 1'b1;
            inflight <= 1'b0;
        end else begin
            empty_q  <= bus.fifo_empty;
            inflight <= bus.fifo_r_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid_mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (capture) begin
            skid_mem[wr_ptr] <= bus.fifo_r_data;
            wr_ptr           <= wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({capture, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(capture && (count == CW'(SKID_DEPTH)) && !pop));

    a_credit: assert property (@(posedge clk) disable iff (rst)
        (SW'(count) + SW'(inflight)) <= SW'(SKID_DEPTH));
endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// tb/tb_sync_fifo_stream_reader.sv - directed bench with FIFO model and stream scoreboard
module tb_sync_fifo_stream_reader;
    logic       clk;
    logic       rst;
    logic [1:0] buf_count;
    logic       push;
    logic [31:0] push_data;

    int total = 0;
    int bad   = 0;

    sync_fifo_stream_reader_if #(.WIDTH(32)) bus ();

    sync_fifo_stream_reader #(.WIDTH(32), .SKID_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .buf_count (buf_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Paired sync FIFO: registered read, empty flag reflects post-update occupancy.
    logic [31:0] fmem [32];
    int fhead, ftail, focc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fhead <= 0;
            ftail <= 0;
            focc  <= 0;
            bus.fifo_r_data_valid <= 1'b0;
            bus.fifo_r_data       <= '0;
        end else begin
            if (push) begin
                fmem[ftail] <= push_data;
                ftail       <= (ftail + 1) % 32;
            end
            if (bus.fifo_r_en && focc > 0) begin
                bus.fifo_r_data <= fmem[fhead];
                fhead           <= (fhead + 1) % 32;
            end else begin
                bus.fifo_r_data <= 32'hxxxx_xxxx;
            end
            bus.fifo_r_data_valid <= bus.fifo_r_en && focc > 0;
            focc <= focc + (push ? 1 : 0) - ((bus.fifo_r_en && focc > 0) ? 1 : 0);
        end
    end

    int nxt_occ;
    always @* begin
        nxt_occ = focc + (push ? 1 : 0) - ((bus.fifo_r_en && focc > 0) ? 1 : 0);
        bus.fifo_empty = (nxt_occ == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every word pushed must leave the stream once, in order; occupancy is
    // words delivered by the FIFO minus words consumed.
    logic [31:0] exp_q [$];
    int          model_cnt;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [31:0] exp_w;

    initial begin
        model_cnt  = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                exp_q.delete();
                model_cnt  = 0;
                prev_stall = 1'b0;
            end else begin
                chk("buf_count", 32'(buf_count), 32'(model_cnt));
                chk("buf_le_depth", 32'(buf_count <= 2'd2), 32'd1);
                chk("m_valid_vs_occ", 32'(bus.m_valid), 32'(model_cnt != 0));
                if (prev_stall) begin
                    chk("hold_valid", 32'(bus.m_valid), 32'd1);
                    chk("hold_data", bus.m_data, prev_data);
                end
                if (bus.m_valid && bus.m_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_word got=%h expected=none at %0t", bus.m_data, $time);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (bus.m_data !== exp_w) begin
                            bad++;
                            $display("FAIL stream_order got=%h expected=%h at %0t", bus.m_data, exp_w, $time);
                        end
                    end
                end
                if (push) exp_q.push_back(push_data);
                model_cnt  = model_cnt + (bus.fifo_r_data_valid ? 1 : 0)
                           - ((bus.m_valid && bus.m_ready) ? 1 : 0);
                prev_stall = bus.m_valid && !bus.m_ready;
                prev_data  = bus.m_data;
            end
        end
    end

    task automatic step(input logic p, input logic [31:0] d, input logic r);
        @(negedge clk);
        push       = p;
        push_data  = d;
        bus.m_ready = r;
        #1;
    endtask

    logic        vv [8];
    logic [31:0] dd [8];
    logic [31:0] bw [3];
    int en_cnt, v_cnt, pops, gaps;
    logic seen, found;
    logic [31:0] got;

    initial begin
        rst = 1'b1;
        push = 1'b0;
        push_data = '0;
        bus.m_ready = 1'b0;
        bw[0] = 32'hA1; bw[1] = 32'hB2; bw[2] = 32'hC3;

        step(0, 0, 0);
        chk("rst_r_en", 32'(bus.fifo_r_en), 32'd0);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_data", bus.m_data, 32'd0);
        chk("rst_buf_count", 32'(buf_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 1);
        step(0, 0, 1);

        // Basic: three words, first m_valid three cycles after fifo_empty falls.
        for (int c = 0; c < 8; c++) begin
            step(c < 3, (c < 3) ? bw[c % 3] : 32'd0, 1);
            if (c == 0) chk("basic_empty_fall", 32'(bus.fifo_empty), 32'd0);
            vv[c] = bus.m_valid;
            dd[c] = bus.m_data;
        end
        for (int c = 0; c < 8; c++) begin
            chk("basic_valid", 32'(vv[c]), 32'(c >= 3 && c <= 5));
            if (c >= 3 && c <= 5) chk("basic_data", dd[c], bw[c - 3]);
        end

        // Back-pressure: 8 words queued, consumer stalled for 10 cycles.
        en_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step(c < 8, 32'h100 + 32'(c), 0);
            en_cnt += bus.fifo_r_en ? 1 : 0;
            if (c == 9) begin
                chk("bp_buf_count", 32'(buf_count), 32'd2);
                chk("bp_head", bus.m_data, 32'h100);
            end
        end
        chk("bp_r_en_pulses", 32'(en_cnt), 32'd2);
        v_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step(0, 0, 1);
            if (c < 8) v_cnt += bus.m_valid ? 1 : 0;
            if (c == 0) chk("bp_first", bus.m_data, 32'h100);
            if (c == 7) chk("bp_last", bus.m_data, 32'h107);
            if (c == 8) chk("bp_drained", 32'(bus.m_valid), 32'd0);
        end
        chk("bp_burst_len", 32'(v_cnt), 32'd8);

        // Alternating ready over 16 words.
        pops = 0;
        for (int c = 0; c < 80 && pops < 16; c++) begin
            step(c < 16, 32'(c), (c % 2) == 0);
            if (bus.m_valid && bus.m_ready) pops++;
        end
        chk("alt_pops", 32'(pops), 32'd16);
        for (int c = 0; c < 4; c++) step(0, 0, 1);
        chk("alt_idle", 32'(bus.m_valid), 32'd0);

        // Empty boundary: one word, then nothing.
        en_cnt = 0;
        v_cnt  = 0;
        for (int c = 0; c < 12; c++) begin
            step(c == 0, 32'h5, 1);
            en_cnt += bus.fifo_r_en ? 1 : 0;
            v_cnt  += bus.m_valid ? 1 : 0;
            if (c == 3) chk("empty_word", bus.m_data, 32'h5);
        end
        chk("empty_r_en_once", 32'(en_cnt), 32'd1);
        chk("empty_valid_once", 32'(v_cnt), 32'd1);
        chk("empty_r_en_idle", 32'(bus.fifo_r_en), 32'd0);

        // Producer and consumer both at full rate.
        pops = 0;
        gaps = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && pops < 20; c++) begin
            step(c < 20, 32'h200 + 32'(c), 1);
            if (bus.m_valid) seen = 1'b1;
            else if (seen) gaps++;
            if (bus.m_valid && bus.m_ready) pops++;
        end
        chk("stream_pops", 32'(pops), 32'd20);
        chk("stream_gaps", 32'(gaps), 32'd0);
        for (int c = 0; c < 3; c++) step(0, 0, 1);

        // Reset while a word is held and another is in flight.
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step(c < 4, 32'h300 + 32'(c), 0);
            if (buf_count == 2'd1 && bus.fifo_r_data_valid) found = 1'b1;
        end
        chk("mid_setup", 32'(found), 32'd1);
        @(negedge clk);
        rst  = 1'b1;
        push = 1'b0;
        #1;
        chk("mid_m_valid", 32'(bus.m_valid), 32'd0);
        chk("mid_buf_count", 32'(buf_count), 32'd0);
        chk("mid_r_en", 32'(bus.fifo_r_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pops = 0;
        got  = '0;
        for (int c = 0; c < 10; c++) begin
            step(c == 0, 32'h77, 1);
            if (bus.m_valid && bus.m_ready) begin
                pops++;
                got = bus.m_data;
            end
        end
        chk("mid_pops", 32'(pops), 32'd1);
        chk("mid_word", got, 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
